// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if
// Groups the producer and consumer signals of the ALU result FIFO.
//   flush            : synchronous clear of contents and drop counter
//   in_valid/res_in/op_in/in_ready     : push side (ALU result + opcode tag)
//   out_valid/res_out/op_out/out_ready : pop side, show-ahead head entry
//   count/full/empty/drop_cnt          : occupancy and lost-push status
// The master modport is the environment (ALU + consumer); the slave modport
// is the FIFO itself.
interface alu_result_fifo_if #(
  parameter int CW     = 3,
  parameter int DROP_W = 8
);
  logic              flush;
  logic              in_valid;
  logic [7:0]        res_in;
  logic [1:0]        op_in;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        res_out;
  logic [1:0]        op_out;
  logic              out_ready;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output flush, in_valid, res_in, op_in, out_ready,
    input  in_ready, out_valid, res_out, op_out, count, full, empty, drop_cnt
  );

  modport slave (
    input  flush, in_valid, res_in, op_in, out_ready,
    output in_ready, out_valid, res_out, op_out, count, full, empty, drop_cnt
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Show-ahead FIFO capturing registered signed ALU results with their opcode
// tag. The ALU cannot stall, so a push into a full FIFO is dropped and counted
// in a saturating counter.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : alu_result_fifo_if.slave (handshake, data and status signals)
module alu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH) + 1,
  parameter int DROP_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  alu_result_fifo_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [9:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic full, empty, push, pop, drop;
  logic [9:0] head;

  // Status comes only from the registered count, so ready never depends on
  // a same-cycle pop (full + pop + push is a drop, not a pass-through).
  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign push  = bus.in_valid & ~full;
  assign drop  = bus.in_valid & full;
  assign pop   = ~empty & bus.out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; stale entries are never visible because the head
  // is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push && !bus.flush) mem_q[wr_ptr_q] <= {bus.op_in, bus.res_in};
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    bus.in_ready  = ~full;
    bus.out_valid = ~empty;
    bus.count     = count_q;
    bus.full      = full;
    bus.empty     = empty;
    bus.drop_cnt  = drop_cnt_q;
    bus.res_out   = empty ? 8'd0 : head[7:0];
    bus.op_out    = empty ? 2'd0 : head[9:8];
  end

endmodule
